// File: rtl/style_check_sched_pkg.sv
// Shared types and defaults for the style-check sequencer slice.
package style_check_pkg;

    localparam int NPROP_DEF = 8;
    localparam int CW_DEF    = 6;
    localparam int DW_DEF    = 5;
    // Result fields are sized for any reasonable NPROP; the top zero-extends into them.
    localparam int RW        = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DISP = 2'd2,
        DONE = 2'd3
    } state_e;

    typedef struct packed {
        logic [RW-1:0] prim_count;
        logic [RW-1:0] first_prim;
        logic          display_ok;
    } result_t;

endpackage

// File: rtl/style_check_sched_if.sv
// Descriptor-in / result-out bus between the style pipeline and the check sequencer.
interface style_check_sched_if
    import style_check_pkg::*;
#(
    parameter int NPROP = NPROP_DEF,
    parameter int CW    = CW_DEF,
    parameter int DW    = DW_DEF,
    parameter int IW    = $clog2(NPROP + 1)
);
    // Both channels are strict valid/ready: a transfer happens on a rising clk edge
    // where valid && ready; valid may not drop and payload may not change until then.
    logic                in_valid;
    logic                in_ready;
    logic                in_element_valid;
    logic                in_is_svg;
    logic [CW-1:0]       in_style_type;
    logic [DW-1:0]       in_display;
    logic [NPROP*CW-1:0] in_class_types;
    logic [IW-1:0]       in_count;

    logic                out_valid;
    logic                out_ready;
    logic [IW-1:0]       out_prim_count;
    logic [IW-1:0]       out_first_prim;
    logic                out_display_ok;

    modport master (
        output in_valid, in_element_valid, in_is_svg, in_style_type, in_display,
               in_class_types, in_count, out_ready,
        input  in_ready, out_valid, out_prim_count, out_first_prim, out_display_ok
    );

    modport slave (
        input  in_valid, in_element_valid, in_is_svg, in_style_type, in_display,
               in_class_types, in_count, out_ready,
        output in_ready, out_valid, out_prim_count, out_first_prim, out_display_ok
    );

endinterface

// File: rtl/style_check_sched_prim_scan.sv
// Walks the held class-type entries one per step through a single comparator,
// accumulating the match count and latching the first matching index.
module prim_scan_unit #(
    parameter int NPROP = 8,
    parameter int CW    = 6,
    parameter int IW    = $clog2(NPROP + 1)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                clear,
    input  logic                start,
    input  logic                step,
    input  logic [NPROP*CW-1:0] class_types,
    input  logic [IW-1:0]       count,
    input  logic [CW-1:0]       prim_class,
    output logic                last,
    output logic [IW-1:0]       prim_count,
    output logic [IW-1:0]       first_prim
);

    logic [IW-1:0] idx;
    logic [CW-1:0] entry;
    logic          match;

    always_comb begin
        entry = '0;
        for (int i = 0; i < NPROP; i++) begin
            if (idx == IW'(i)) begin
                entry = class_types[i*CW +: CW];
            end
        end
    end

    assign match = (entry == prim_class);
    // Only meaningful while stepping, where count is known to be non-zero.
    assign last  = (idx == count - IW'(1));

    always_ff @(posedge clk) begin
        if (!rst_n || clear || start) begin
            idx        <= '0;
            prim_count <= '0;
            first_prim <= IW'(NPROP);
        end else if (step) begin
            idx <= idx + IW'(1);
            if (match) begin
                prim_count <= prim_count + IW'(1);
                if (first_prim == IW'(NPROP)) begin
                    first_prim <= idx;
                end
            end
        end
    end

endmodule

// File: rtl/style_check_sched.sv
// Serialises per-element style checks: one class-type compare per cycle, then a
// single display-validity evaluation, returning one result record per descriptor.
module style_check_sched
    import style_check_pkg::*;
#(
    parameter int NPROP = NPROP_DEF,
    parameter int CW    = CW_DEF,
    parameter int DW    = DW_DEF,
    parameter int IW    = $clog2(NPROP + 1)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                flush,
    input  logic [CW-1:0]       cfg_primitive_class,
    input  logic [CW-1:0]       cfg_nopseudo,
    input  logic [DW-1:0]       cfg_none,
    input  logic [DW-1:0]       cfg_inline,
    input  logic [DW-1:0]       cfg_block,
    style_check_sched_if.slave  bus,
    output logic [1:0]          dbg_state,
    output result_t             dbg_result
);

    localparam logic [1:0] S_IDLE = IDLE;
    localparam logic [1:0] S_SCAN = SCAN;
    localparam logic [1:0] S_DISP = DISP;
    localparam logic [1:0] S_DONE = DONE;

    logic [1:0]          state_q;
    logic                out_valid_q;
    logic [IW-1:0]       prim_q;
    logic [IW-1:0]       first_q;
    logic                ok_q;

    logic                h_element_valid;
    logic                h_is_svg;
    logic [CW-1:0]       h_style_type;
    logic [DW-1:0]       h_display;
    logic [NPROP*CW-1:0] h_class_types;
    logic [IW-1:0]       h_count;

    logic                accept;
    logic [IW-1:0]       count_c;
    logic                disp_ok;
    logic                scan_last;
    logic [IW-1:0]       scan_prim_count;
    logic [IW-1:0]       scan_first_prim;

    // Ready is withheld during reset/flush so an offered descriptor is never lost silently.
    assign bus.in_ready = rst_n && !flush && (state_q == S_IDLE);
    assign accept       = bus.in_valid && bus.in_ready;
    assign count_c      = (bus.in_count > IW'(NPROP)) ? IW'(NPROP) : bus.in_count;

    assign disp_ok = h_element_valid && h_is_svg && (h_style_type == cfg_nopseudo) &&
                     ((h_display == cfg_none) || (h_display == cfg_inline) ||
                      (h_display == cfg_block));

    prim_scan_unit #(.NPROP(NPROP), .CW(CW), .IW(IW)) u_scan (
        .clk         (clk),
        .rst_n       (rst_n),
        .clear       (flush),
        .start       (accept),
        .step        (state_q == S_SCAN),
        .class_types (h_class_types),
        .count       (h_count),
        .prim_class  (cfg_primitive_class),
        .last        (scan_last),
        .prim_count  (scan_prim_count),
        .first_prim  (scan_first_prim)
    );

    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            state_q         <= S_IDLE;
            out_valid_q     <= 1'b0;
            prim_q          <= '0;
            first_q         <= IW'(NPROP);
            ok_q            <= 1'b0;
            h_element_valid <= 1'b0;
            h_is_svg        <= 1'b0;
            h_style_type    <= '0;
            h_display       <= '0;
            h_class_types   <= '0;
            h_count         <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (accept) begin
                        h_element_valid <= bus.in_element_valid;
                        h_is_svg        <= bus.in_is_svg;
                        h_style_type    <= bus.in_style_type;
                        h_display       <= bus.in_display;
                        h_class_types   <= bus.in_class_types;
                        h_count         <= count_c;
                        state_q         <= (count_c != '0) ? S_SCAN : S_DISP;
                    end
                end
                S_SCAN: begin
                    if (scan_last) begin
                        state_q <= S_DISP;
                    end
                end
                S_DISP: begin
                    prim_q  <= scan_prim_count;
                    first_q <= scan_first_prim;
                    ok_q    <= disp_ok;
                    state_q <= S_DONE;
                end
                S_DONE: begin
                    // First DONE cycle publishes the record; later cycles wait for the consumer.
                    if (!out_valid_q) begin
                        out_valid_q <= 1'b1;
                    end else if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        state_q     <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign bus.out_valid      = out_valid_q;
    assign bus.out_prim_count = prim_q;
    assign bus.out_first_prim = first_q;
    assign bus.out_display_ok = ok_q;

    assign dbg_state  = state_q;
    assign dbg_result = '{prim_count: RW'(prim_q), first_prim: RW'(first_q), display_ok: ok_q};

endmodule

// File: tb/tb_style_check_sched.sv
// Directed scoreboard bench for style_check_sched: the driver pushes expected records
// and latencies, an independent monitor compares whenever a result is presented.
module tb_style_check_sched;
    import style_check_pkg::*;

    localparam int NPROP = 8;
    localparam int CW    = 6;
    localparam int DW    = 5;
    localparam int IW    = 4;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic flush = 1'b0;
    logic [CW-1:0] cfg_primitive_class, cfg_nopseudo;
    logic [DW-1:0] cfg_none, cfg_inline, cfg_block;
    logic [1:0]    dbg_state;
    result_t       dbg_result;

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    style_check_sched_if #(.NPROP(NPROP), .CW(CW), .DW(DW), .IW(IW)) bus ();

    style_check_sched #(.NPROP(NPROP), .CW(CW), .DW(DW), .IW(IW)) dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .flush               (flush),
        .cfg_primitive_class (cfg_primitive_class),
        .cfg_nopseudo        (cfg_nopseudo),
        .cfg_none            (cfg_none),
        .cfg_inline          (cfg_inline),
        .cfg_block           (cfg_block),
        .bus                 (bus),
        .dbg_state           (dbg_state),
        .dbg_result          (dbg_result)
    );

    // ---------------- scoreboard ----------------
    int checks = 0;
    int errors = 0;
    logic [8:0] exp_q[$];   // {prim_count[3:0], first_prim[3:0], display_ok}
    int         lat_q[$];
    int         accept_edge = 0;
    logic       prev_valid = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && !flush) begin
            if (bus.in_valid && bus.in_ready) accept_edge = cyc + 1;
            if (bus.out_valid) begin
                if (!prev_valid) begin
                    if (lat_q.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL latency no expectation pending (t=%0t)", $time);
                    end else begin
                        check("latency", cyc - accept_edge, lat_q.pop_front());
                    end
                end
                if (exp_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL out_record unexpected result (t=%0t)", $time);
                end else begin
                    check("out_prim_count", bus.out_prim_count, exp_q[0][8:5]);
                    check("out_first_prim", bus.out_first_prim, exp_q[0][4:1]);
                    check("out_display_ok", bus.out_display_ok, exp_q[0][0]);
                    check("in_ready_busy", bus.in_ready, 0);
                    if (bus.out_ready) void'(exp_q.pop_front());
                end
            end
        end
        prev_valid = bus.out_valid;
    end

    // ---------------- driver tasks ----------------
    function automatic logic [NPROP*CW-1:0] mk(input logic [CW-1:0] e0, e1, e2, e3,
                                                input logic [CW-1:0] e4, e5, e6, e7);
        return {e7, e6, e5, e4, e3, e2, e1, e0};
    endfunction

    task automatic send(input logic [IW-1:0] cnt, input logic [NPROP*CW-1:0] types,
                        input logic ev, input logic svg, input logic [CW-1:0] st,
                        input logic [DW-1:0] dp, input logic [3:0] ep, input logic [3:0] ef,
                        input logic eo, input int lat, output int waits);
        exp_q.push_back({ep, ef, eo});
        lat_q.push_back(lat);
        bus.in_valid         = 1'b1;
        bus.in_count         = cnt;
        bus.in_class_types   = types;
        bus.in_element_valid = ev;
        bus.in_is_svg        = svg;
        bus.in_style_type    = st;
        bus.in_display       = dp;
        waits = 0;
        while (1) begin
            @(negedge clk);
            if (bus.in_ready) break;
            waits++;
            if (waits > 50) begin
                checks++; errors++;
                $display("FAIL accept_timeout waited=%0d limit=50", waits);
                break;
            end
        end
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (1) begin
            @(negedge clk);
            if (dbg_state == 2'd0 && !bus.out_valid) break;
            n++;
            if (n > 60) begin
                checks++; errors++;
                $display("FAIL idle_timeout state=%0d required=0", dbg_state);
                break;
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic wait_valid();
        int n = 0;
        while (1) begin
            @(negedge clk);
            if (bus.out_valid) break;
            n++;
            if (n > 60) begin
                checks++; errors++;
                $display("FAIL valid_timeout out_valid=%0d required=1", bus.out_valid);
                break;
            end
        end
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_state"}, dbg_state, 0);
        check({tag, "_out_valid"}, bus.out_valid, 0);
        check({tag, "_prim_count"}, bus.out_prim_count, 0);
        check({tag, "_first_prim"}, bus.out_first_prim, NPROP);
        check({tag, "_display_ok"}, bus.out_display_ok, 0);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int w;
        logic [NPROP*CW-1:0] all3;
        cfg_primitive_class = 6'd3;
        cfg_nopseudo        = 6'd0;
        cfg_none            = 5'd0;
        cfg_inline          = 5'd1;
        cfg_block           = 5'd2;
        bus.in_valid = 1'b0; bus.in_count = '0; bus.in_class_types = '0;
        bus.in_element_valid = 1'b0; bus.in_is_svg = 1'b0;
        bus.in_style_type = '0; bus.in_display = '0;
        bus.out_ready = 1'b1;
        all3 = mk(3, 3, 3, 3, 3, 3, 3, 3);

        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check_reset_vals("reset");
        check("reset_in_ready", bus.in_ready, 1);
        check("reset_dbg_first", dbg_result.first_prim, NPROP);
        @(posedge clk); #1;

        // scan with matches
        send(4, mk(3, 5, 3, 1, 0, 0, 0, 0), 1, 1, 0, 2, 2, 0, 1, 6, w);
        wait_idle();
        // empty scan, invalid display value
        send(0, all3, 1, 1, 0, 7, 0, 8, 0, 2, w);
        wait_idle();
        // count clamped to NPROP
        send(12, all3, 1, 1, 0, 1, 8, 0, 1, 10, w);
        wait_idle();

        // backpressure in DONE
        bus.out_ready = 1'b0;
        send(2, mk(5, 3, 0, 0, 0, 0, 0, 0), 1, 1, 0, 0, 1, 1, 1, 4, w);
        wait_valid();
        repeat (5) begin
            @(negedge clk);
            check("bp_state_done", dbg_state, 3);
        end
        @(posedge clk); #1 bus.out_ready = 1'b1;
        @(posedge clk); #1;
        check("bp_release_state", dbg_state, 0);
        check("bp_release_valid", bus.out_valid, 0);
        check("bp_release_ready", bus.in_ready, 1);
        send(3, mk(1, 1, 3, 0, 0, 0, 0, 0), 1, 1, 0, 3, 1, 2, 0, 5, w);
        check("bp_next_accept_waits", w, 0);
        wait_idle();

        // pseudo style type
        send(1, mk(3, 0, 0, 0, 0, 0, 0, 0), 1, 1, 1, 0, 1, 0, 0, 3, w);
        wait_idle();

        // flush during SCAN at idx=2, with a descriptor offered in the flush cycle
        send(4, all3, 1, 1, 0, 0, 4, 0, 1, 6, w);
        @(posedge clk);
        @(posedge clk); #1;
        check("flush_pre_state", dbg_state, 1);
        flush = 1'b1;
        exp_q.delete();
        lat_q.delete();
        bus.in_valid = 1'b1;
        bus.in_count = 4'd1;
        @(posedge clk); #1;
        flush = 1'b0;
        bus.in_valid = 1'b0;
        @(negedge clk);
        check_reset_vals("flush");
        check("flush_in_ready", bus.in_ready, 1);
        @(posedge clk); #1;
        send(5, mk(0, 2, 4, 6, 3, 0, 0, 0), 1, 0, 0, 0, 1, 4, 0, 7, w);
        wait_idle();

        // element not valid, two matches across full width
        send(8, mk(1, 2, 3, 4, 5, 6, 7, 3), 0, 1, 0, 1, 2, 2, 0, 10, w);
        wait_idle();

        // reset while holding a result in DONE
        bus.out_ready = 1'b0;
        send(1, mk(5, 0, 0, 0, 0, 0, 0, 0), 1, 1, 0, 1, 0, 8, 1, 3, w);
        wait_valid();
        @(posedge clk); #1;
        rst_n = 1'b0;
        exp_q.delete();
        lat_q.delete();
        @(posedge clk); #1;
        bus.out_ready = 1'b1;
        @(negedge clk);
        check_reset_vals("mid_reset");
        @(posedge clk); #1 rst_n = 1'b1;
        @(negedge clk);
        check("post_reset_in_ready", bus.in_ready, 1);

        repeat (3) @(posedge clk);
        check("queue_drained", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/style_check_sched.md
Name: style_check_sched

Overview:
- Sequencer that serialises per-element style checks onto one shared primitive-class comparator and one display-validity evaluator.
- Accepts an element descriptor carrying up to NPROP declared-property class types.
- Scans the class types one per cycle against the primitive class code, then evaluates display validity once.
- Returns a result record to the style-resolution pipeline over a valid/ready handshake.

Parameters:
- NPROP, 8, maximum class-type entries per descriptor (≥1).
- CW, 6, class/style-type code width.
- DW, 5, display code width.
- IW, $clog2(NPROP+1), width of counts and indices.

Ports:
- clk  in  1  clock.
- rst_n  in  1  synchronous active-low reset. One clock; reset is synchronous and active-low.
- flush  in  1  synchronous abort; returns the block to IDLE.
- cfg_primitive_class  in  CW  primitive class code.
- cfg_nopseudo  in  CW  no-pseudo style-type code.
- cfg_none, cfg_inline, cfg_block  in  DW each  display codes.
- in_valid  in  1  descriptor offered.
- in_ready  out  1  descriptor accepted when in_valid && in_ready.
- in_element_valid  in  1  element-valid flag.
- in_is_svg  in  1  SVG-element flag.
- in_style_type  in  CW  style type.
- in_display  in  DW  display value.
- in_class_types  in  NPROP*CW  packed class types; entry i = bits [i*CW +: CW].
- in_count  in  IW  number of valid entries.
- out_valid  out  1  result available.
- out_ready  in  1  result consumed when out_valid && out_ready.
- out_prim_count  out  IW  number of scanned entries equal to cfg_primitive_class.
- out_first_prim  out  IW  index of the first match; NPROP if there is none.
- out_display_ok  out  1  display-validity result.

Behaviour:
- States: IDLE, SCAN, DISP, DONE. Reset and flush both go to IDLE.
- Reset values: in_ready=1 in IDLE after reset; out_valid=0, out_prim_count=0, out_first_prim=NPROP, out_display_ok=0.
- IDLE: in_ready=1.
  - On accept, capture every in_* field into holding registers.
  - Clamp the captured count to NPROP when in_count>NPROP.
  - Clear idx, prim_count and first_prim (first_prim←NPROP).
  - Next state is SCAN if the clamped count>0, else DISP.
- SCAN: each cycle compare entry[idx] to cfg_primitive_class.
  - On a match: prim_count+1; first_prim←idx if first_prim==NPROP.
  - idx+1 each cycle. Go to DISP after the cycle where idx==count−1.
- DISP, one cycle: display_ok = element_valid && is_svg && style_type==cfg_nopseudo && display∈{cfg_none, cfg_inline, cfg_block}. Go to DONE.
- DONE: out_valid=1 and outputs held stable. When out_ready is high, go to IDLE next cycle and drop out_valid.
- in_ready is 0 in every state except IDLE. No pipelining: one descriptor in flight.
- Latency: out_valid rises count+2 cycles after the accept edge, with count clamped. count=0 gives 2 cycles.
- Config ports are sampled live, never registered. They must be stable from accept until the DONE handshake; otherwise results are undefined.
- flush has priority over every transition, including a DONE handshake in the same cycle.
  - On flush: outputs return to reset values; a descriptor offered in that cycle is not accepted.
- rst_n low mid-operation: the same as flush.
- Comparisons are on equal widths and unsigned. prim_count cannot overflow, since it is at most NPROP.

Decomposition:
- Package style_check_pkg holds:
  - state enum {IDLE, SCAN, DISP, DONE};
  - default CW/DW constants;
  - a packed result struct {prim_count, first_prim, display_ok}.
- One natural sub-module: prim_scan_unit. It holds the idx counter, the entry mux, the shared comparator, the prim_count accumulator and the first-match latch, driven by start/step signals from the FSM.

Test Plan:
- Common config for all scenarios: prim=3, nopseudo=0, none=0, inline=1, block=2, NPROP=8.
- Scan with matches: count=4, types {3,5,3,1}, elem_valid=1, svg=1, style=0, display=2 → out_valid 6 cycles after accept; prim_count=2, first_prim=0, display_ok=1.
- Empty scan: count=0, display=7 → out_valid 2 cycles after accept; prim_count=0, first_prim=8, display_ok=0.
- Clamp: count=12, all 8 types=3 → out_valid 10 cycles after accept; prim_count=8, first_prim=0.
- Backpressure: hold out_ready=0 for 5 cycles in DONE → outputs stable and in_ready=0 throughout; raise out_ready → IDLE next cycle, and a new descriptor is accepted the following cycle.
- Flush in SCAN at idx=2 → next cycle IDLE, out_valid=0, in_ready=1; a new descriptor completes correctly.
- Pseudo style: style=1, everything else valid → display_ok=0.
- Reset: assert rst_n=0 in DONE → outputs return to reset values next cycle.
